// File: rtl/rob_unit.sv
// 8-entry reorder buffer: in-order allocate, out-of-order CDB completion, in-order retire.
// Optional ROB_FLUSH_EN macro adds a flush input that discards all in-flight entries.
module rob_unit #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned IDX_W  = 3,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_W  = 4
) (
   input  logic              clk1,
   input  logic              rst_n,
`ifdef ROB_FLUSH_EN
   input  logic              flush,
`endif
   input  logic              alloc_valid,
   input  logic [3:0]        alloc_func,
   input  logic [REG_W-1:0]  alloc_rd,
   output logic              alloc_ready,
   output logic [IDX_W-1:0]  alloc_tag,
   input  logic              cdb_valid,
   input  logic [IDX_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic [IDX_W-1:0]  look_tag_a,
   output logic              look_rdy_a,
   output logic [DATA_W-1:0] look_data_a,
   input  logic [IDX_W-1:0]  look_tag_b,
   output logic              look_rdy_b,
   output logic [DATA_W-1:0] look_data_b,
   output logic              commit_valid,
   output logic              commit_we,
   output logic [REG_W-1:0]  commit_rd,
   output logic [IDX_W-1:0]  commit_tag,
   output logic [DATA_W-1:0] commit_data,
   output logic [IDX_W:0]    count,
   output logic              empty,
   output logic              full
);

   localparam logic [IDX_W:0] FullCnt = (IDX_W+1)'(DEPTH);

   logic              busy_q  [DEPTH];
   logic              ready_q [DEPTH];
   logic [3:0]        func_q  [DEPTH];
   logic [REG_W-1:0]  rd_q    [DEPTH];
   logic [DATA_W-1:0] data_q  [DEPTH];

   logic [IDX_W-1:0]  head_q, tail_q;
   logic [IDX_W:0]    count_q;
   logic              commit_valid_q, commit_we_q;
   logic [REG_W-1:0]  commit_rd_q;
   logic [IDX_W-1:0]  commit_tag_q;
   logic [DATA_W-1:0] commit_data_q;

   logic flush_int, alloc_fire, cdb_fire, commit_fire;

`ifdef ROB_FLUSH_EN
   assign flush_int = flush;
`else
   assign flush_int = 1'b0;
`endif

   // Full check deliberately ignores a same-cycle commit.
   assign alloc_ready = (count_q != FullCnt) && !flush_int;
   assign alloc_tag   = tail_q;
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign cdb_fire    = cdb_valid && busy_q[cdb_tag] && !ready_q[cdb_tag];
   assign commit_fire = busy_q[head_q] && ready_q[head_q];

   assign count        = count_q;
   assign empty        = (count_q == '0);
   assign full         = (count_q == FullCnt);
   assign commit_valid = commit_valid_q;
   assign commit_we    = commit_we_q;
   assign commit_rd    = commit_rd_q;
   assign commit_tag   = commit_tag_q;
   assign commit_data  = commit_data_q;

   // Stores and branches do not write the register bank.
   function automatic logic writes_reg(input logic [3:0] func);
      return !(func inside {4'b0101, 4'b0110, 4'b0111});
   endfunction

   // Operand lookup with same-cycle CDB bypass taking precedence over stored data.
   always_comb begin
      look_rdy_a  = 1'b0;
      look_data_a = '0;
      if (busy_q[look_tag_a]) begin
         if (cdb_valid && cdb_tag == look_tag_a) begin
            look_rdy_a  = 1'b1;
            look_data_a = cdb_data;
         end else if (ready_q[look_tag_a]) begin
            look_rdy_a  = 1'b1;
            look_data_a = data_q[look_tag_a];
         end
      end
   end

   always_comb begin
      look_rdy_b  = 1'b0;
      look_data_b = '0;
      if (busy_q[look_tag_b]) begin
         if (cdb_valid && cdb_tag == look_tag_b) begin
            look_rdy_b  = 1'b1;
            look_data_b = cdb_data;
         end else if (ready_q[look_tag_b]) begin
            look_rdy_b  = 1'b1;
            look_data_b = data_q[look_tag_b];
         end
      end
   end

   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         commit_valid_q <= 1'b0;
         commit_we_q    <= 1'b0;
         commit_rd_q    <= '0;
         commit_tag_q   <= '0;
         commit_data_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            busy_q[i]  <= 1'b0;
            ready_q[i] <= 1'b0;
         end
      end else if (flush_int) begin
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         commit_valid_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            busy_q[i]  <= 1'b0;
            ready_q[i] <= 1'b0;
         end
      end else begin
         commit_valid_q <= commit_fire;
         if (commit_fire) begin
            commit_we_q     <= writes_reg(func_q[head_q]);
            commit_rd_q     <= rd_q[head_q];
            commit_tag_q    <= head_q;
            commit_data_q   <= data_q[head_q];
            busy_q[head_q]  <= 1'b0;
            ready_q[head_q] <= 1'b0;
            head_q          <= head_q + IDX_W'(1);
         end
         if (cdb_fire) begin
            data_q[cdb_tag]  <= cdb_data;
            ready_q[cdb_tag] <= 1'b1;
         end
         if (alloc_fire) begin
            busy_q[tail_q]  <= 1'b1;
            ready_q[tail_q] <= 1'b0;
            func_q[tail_q]  <= alloc_func;
            rd_q[tail_q]    <= alloc_rd;
            tail_q          <= tail_q + IDX_W'(1);
         end
         count_q <= count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
      end
   end

endmodule

// File: tb/tb_rob_unit.sv
// Directed self-checking bench for rob_unit; flush scenario built only with ROB_FLUSH_EN.
module tb_rob_unit;

   logic        clk1 = 1'b0;
   logic        rst_n;
`ifdef ROB_FLUSH_EN
   logic        flush;
`endif
   logic        alloc_valid;
   logic [3:0]  alloc_func;
   logic [3:0]  alloc_rd;
   logic        alloc_ready;
   logic [2:0]  alloc_tag;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [15:0] cdb_data;
   logic [2:0]  look_tag_a, look_tag_b;
   logic        look_rdy_a, look_rdy_b;
   logic [15:0] look_data_a, look_data_b;
   logic        commit_valid, commit_we;
   logic [3:0]  commit_rd;
   logic [2:0]  commit_tag;
   logic [15:0] commit_data;
   logic [3:0]  count;
   logic        empty, full;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk1 = ~clk1;

   rob_unit dut (
      .clk1        (clk1),
      .rst_n       (rst_n),
`ifdef ROB_FLUSH_EN
      .flush       (flush),
`endif
      .alloc_valid (alloc_valid),
      .alloc_func  (alloc_func),
      .alloc_rd    (alloc_rd),
      .alloc_ready (alloc_ready),
      .alloc_tag   (alloc_tag),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .cdb_data    (cdb_data),
      .look_tag_a  (look_tag_a),
      .look_rdy_a  (look_rdy_a),
      .look_data_a (look_data_a),
      .look_tag_b  (look_tag_b),
      .look_rdy_b  (look_rdy_b),
      .look_data_b (look_data_b),
      .commit_valid(commit_valid),
      .commit_we   (commit_we),
      .commit_rd   (commit_rd),
      .commit_tag  (commit_tag),
      .commit_data (commit_data),
      .count       (count),
      .empty       (empty),
      .full        (full)
   );

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk1);
      #1;
   endtask

   task automatic idle_inputs();
`ifdef ROB_FLUSH_EN
      flush = 1'b0;
`endif
      alloc_valid = 1'b0;
      alloc_func  = 4'h0;
      alloc_rd    = 4'h0;
      cdb_valid   = 1'b0;
      cdb_tag     = 3'd0;
      cdb_data    = 16'h0;
      look_tag_a  = 3'd0;
      look_tag_b  = 3'd0;
   endtask

   task automatic reset_dut();
      idle_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic alloc_n(input int n);
      for (int i = 0; i < n; i++) begin
         alloc_valid = 1'b1;
         alloc_func  = 4'h0;
         alloc_rd    = 4'(i + 1);
         step();
      end
      alloc_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_dut();
      #1;
      n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
      n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
      n_cmp++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_alloc_ready got %b want 1", alloc_ready); end
      n_cmp++; if (alloc_tag !== 3'd0) begin n_err++; $display("FAIL reset_alloc_tag got %0d want 0", alloc_tag); end
      n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL reset_commit_valid got %b want 0", commit_valid); end
      n_cmp++; if ({commit_we, commit_rd, commit_tag, commit_data} !== 24'h0)
         begin n_err++; $display("FAIL reset_commit_fields got %h want 0", {commit_we, commit_rd, commit_tag, commit_data}); end
   endtask

   task automatic test_inorder_retire();
      logic [3:0]  fn  [3] = '{4'h0, 4'h2, 4'h1};
      logic [3:0]  rd  [3] = '{4'd3, 4'd5, 4'd7};
      logic [15:0] dat [3] = '{16'h0011, 16'h0020, 16'h0009};
      reset_dut();
      for (int i = 0; i < 3; i++) begin
         alloc_valid = 1'b1;
         alloc_func  = fn[i];
         alloc_rd    = rd[i];
         #1;
         n_cmp++; if (alloc_tag !== 3'(i)) begin n_err++; $display("FAIL ino_alloc_tag%0d got %0d want %0d", i, alloc_tag, i); end
         step();
      end
      alloc_valid = 1'b0;
      n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL ino_count3 got %0d want 3", count); end
      cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 16'h0009;
      step();
      cdb_tag = 3'd0; cdb_data = 16'h0011;
      step();
      n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL ino_no_same_edge_commit got %b want 0", commit_valid); end
      cdb_tag = 3'd1; cdb_data = 16'h0020;
      step();
      cdb_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({commit_valid, commit_we, commit_tag, commit_rd, commit_data} !== {1'b1, 1'b1, 3'(i), rd[i], dat[i]}) begin
            n_err++;
            $display("FAIL ino_commit%0d got v=%b we=%b tag=%0d rd=%0d d=%h want v=1 we=1 tag=%0d rd=%0d d=%h",
                     i, commit_valid, commit_we, commit_tag, commit_rd, commit_data, i, rd[i], dat[i]);
         end
         step();
      end
      n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL ino_pulse_end got %b want 0", commit_valid); end
      n_cmp++; if (commit_rd !== 4'd7) begin n_err++; $display("FAIL ino_rd_hold got %0d want 7", commit_rd); end
      n_cmp++; if (empty !== 1'b1 || count !== 4'd0) begin n_err++; $display("FAIL ino_drained got cnt=%0d want 0", count); end
   endtask

   task automatic test_full_wrap();
      reset_dut();
      for (int i = 0; i < 8; i++) begin
         alloc_valid = 1'b1;
         alloc_func  = 4'h0;
         alloc_rd    = 4'(i + 1);
         #1;
         n_cmp++; if (alloc_tag !== 3'(i)) begin n_err++; $display("FAIL full_alloc_tag%0d got %0d want %0d", i, alloc_tag, i); end
         step();
      end
      n_cmp++; if (full !== 1'b1 || count !== 4'd8) begin n_err++; $display("FAIL full_flag got full=%b cnt=%0d want 1/8", full, count); end
      n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_alloc_ready got %b want 0", alloc_ready); end
      alloc_rd  = 4'd15;
      cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'h1234;
      step();
      cdb_valid = 1'b0;
      n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL full_ignored_alloc got cnt=%0d want 8", count); end
      #1;
      n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL full_no_commit_credit got %b want 0", alloc_ready); end
      step();
      n_cmp++;
      if ({commit_valid, commit_tag, commit_rd, commit_data} !== {1'b1, 3'd0, 4'd1, 16'h1234}) begin
         n_err++;
         $display("FAIL full_commit0 got v=%b tag=%0d rd=%0d d=%h want v=1 tag=0 rd=1 d=1234",
                  commit_valid, commit_tag, commit_rd, commit_data);
      end
      n_cmp++; if (count !== 4'd7) begin n_err++; $display("FAIL full_count7 got %0d want 7", count); end
      alloc_rd = 4'd9;
      #1;
      n_cmp++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0)
         begin n_err++; $display("FAIL wrap_alloc got rdy=%b tag=%0d want 1/0", alloc_ready, alloc_tag); end
      step();
      alloc_valid = 1'b0;
      n_cmp++; if (full !== 1'b1 || count !== 4'd8) begin n_err++; $display("FAIL wrap_refull got cnt=%0d want 8", count); end
   endtask

   task automatic test_non_writing();
      logic [3:0] fn [4] = '{4'b0101, 4'b0110, 4'b0111, 4'b1111};
      logic       we [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         alloc_valid = 1'b1;
         alloc_func  = fn[i];
         alloc_rd    = 4'd2;
         step();
      end
      alloc_valid = 1'b0;
      for (int i = 0; i <= 4; i++) begin
         cdb_valid = (i < 4);
         cdb_tag   = 3'(i);
         cdb_data  = 16'h0050 + 16'(i);
         step();
         if (i > 0) begin
            n_cmp++;
            if ({commit_valid, commit_we, commit_rd, commit_tag} !== {1'b1, we[i-1], 4'd2, 3'(i - 1)}) begin
               n_err++;
               $display("FAIL nowr_commit%0d got v=%b we=%b rd=%0d tag=%0d want v=1 we=%b rd=2 tag=%0d",
                        i - 1, commit_valid, commit_we, commit_rd, commit_tag, we[i-1], i - 1);
            end
         end
      end
   endtask

   task automatic test_lookup_bypass();
      reset_dut();
      alloc_n(5);
      look_tag_a = 3'd4;
      look_tag_b = 3'd5;
      #1;
      n_cmp++; if (look_rdy_a !== 1'b0) begin n_err++; $display("FAIL look_not_ready got %b want 0", look_rdy_a); end
      n_cmp++; if (look_rdy_b !== 1'b0 || look_data_b !== 16'h0)
         begin n_err++; $display("FAIL look_idle_entry got rdy=%b d=%h want 0/0000", look_rdy_b, look_data_b); end
      cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'hBEEF;
      #1;
      n_cmp++; if (look_rdy_a !== 1'b1 || look_data_a !== 16'hBEEF)
         begin n_err++; $display("FAIL look_bypass got rdy=%b d=%h want 1/beef", look_rdy_a, look_data_a); end
      step();
      cdb_valid = 1'b0;
      #1;
      n_cmp++; if (look_rdy_a !== 1'b1 || look_data_a !== 16'hBEEF)
         begin n_err++; $display("FAIL look_stored got rdy=%b d=%h want 1/beef", look_rdy_a, look_data_a); end
      n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL look_head_blocks got %b want 0", commit_valid); end
      // Second CDB to an already-ready entry must not overwrite it.
      cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'h1111;
      look_tag_b = 3'd6;
      step();
      cdb_valid = 1'b0;
      #1;
      n_cmp++; if (look_data_a !== 16'hBEEF) begin n_err++; $display("FAIL look_ready_ignores_cdb got %h want beef", look_data_a); end
      cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 16'h2222;
      #1;
      n_cmp++; if (look_rdy_b !== 1'b0 || look_data_b !== 16'h0)
         begin n_err++; $display("FAIL look_bypass_idle got rdy=%b d=%h want 0/0000", look_rdy_b, look_data_b); end
      step();
      cdb_valid = 1'b0;
      n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL look_count got %0d want 5", count); end
   endtask

`ifdef ROB_FLUSH_EN
   task automatic test_flush();
      reset_dut();
      alloc_n(5);
      cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 16'hAAAA;
      step();
      cdb_tag = 3'd1; cdb_data = 16'hBBBB;
      flush = 1'b1;
      #1;
      n_cmp++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL flush_alloc_ready got %b want 0", alloc_ready); end
      step();
      flush = 1'b0;
      cdb_valid = 1'b0;
      n_cmp++;
      if ({count, empty, commit_valid, alloc_tag} !== {4'd0, 1'b1, 1'b0, 3'd0}) begin
         n_err++;
         $display("FAIL flush_state got cnt=%0d empty=%b cv=%b tag=%0d want 0/1/0/0",
                  count, empty, commit_valid, alloc_tag);
      end
      step();
      n_cmp++; if (commit_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_commit got %b want 0", commit_valid); end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_inorder_retire();
      test_full_wrap();
      test_non_writing();
      test_lookup_bypass();
`ifdef ROB_FLUSH_EN
      test_flush();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
